// File: rtl/if_pkg.sv
// Shared types and default constants for the RV32I instruction-fetch stage.
package if_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
    localparam word_t NOP_INSN_DEFAULT = 32'h0000_0013;

    localparam int unsigned IMEM_DEPTH_DEFAULT = 1024;
    localparam int unsigned IMEM_DEPTH_MIN     = 128;

endpackage

// File: rtl/if_imem.sv
// Read-only word-addressed instruction memory with asynchronous read.
// Words outside the array read as NOP_INSN; there is no address aliasing.
module if_imem
    import if_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
    parameter word_t       NOP_INSN   = NOP_INSN_DEFAULT
) (
    input  logic [XLEN-1:0] addr,
    output logic [XLEN-1:0] rdata
);

    localparam int unsigned AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

    // Contents come from the array initialiser; benches patch words hierarchically.
    word_t mem [0:IMEM_DEPTH-1] = '{default: NOP_INSN};

    logic [XLEN-3:0] word_idx;
    logic            in_range;
    logic            unused_byte_offset;

    assign word_idx           = addr[XLEN-1:2];
    assign in_range           = 32'(word_idx) < 32'(IMEM_DEPTH);
    assign unused_byte_offset = ^addr[1:0];

    assign rdata = in_range ? mem[word_idx[AW-1:0]] : NOP_INSN;

endmodule

// File: rtl/if_fetch_unit.sv
// RV32I fetch stage: PC register with redirect, plus integrated instruction memory.
// Optional IF_BUBBLE_EN: returns NOP for one cycle after any reset or redirect edge.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEFAULT,
    parameter word_t       RESET_PC   = RESET_PC_DEFAULT,
    parameter word_t       NOP_INSN   = NOP_INSN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);

    word_t pc_q;
    word_t pc_d;
    word_t imem_rdata;
    logic  unused_redirect_offset;

    assign unused_redirect_offset = ^redirect_pc[1:0];

    // Next PC: redirect target (word aligned) or sequential +4, wrapping mod 2^32.
    always_comb begin
        pc_d = pc_q + word_t'(4);
        if (redirect_valid) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

    if_imem #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .NOP_INSN   (NOP_INSN)
    ) u_imem (
        .addr  (pc_q),
        .rdata (imem_rdata)
    );

`ifdef IF_BUBBLE_EN
    logic squash_q;

    // Squash the word fetched right after a reset or redirect edge.
    always_ff @(posedge clk) begin
        squash_q <= reset | redirect_valid;
    end

    assign instr = squash_q ? NOP_INSN : imem_rdata;
`else
    assign instr = imem_rdata;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, sequential fetch, redirect, priority, bounds, wrap.
module tb_if_fetch_unit;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic [31:0] instr;

    int n_pass;
    int n_total;

    if_fetch_unit #(
        .IMEM_DEPTH (DEPTH),
        .RESET_PC   (32'h0000_0000),
        .NOP_INSN   (NOP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .instr          (instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Preloaded pattern: word i holds 0xC0DE_0000 | i.
    function automatic logic [31:0] exp_word(input logic [31:0] addr, input logic squashed);
        logic [31:0] idx;
        idx = addr >> 2;
`ifdef IF_BUBBLE_EN
        if (squashed) return NOP;
`else
        if (squashed) begin end
`endif
        if (idx < 32'(DEPTH)) return 32'hC0DE_0000 | idx;
        return NOP;
    endfunction

    // Apply inputs, take one rising edge, then check pc and instr.
    task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc,
                       input logic [31:0] exp_pc, input string tag);
        reset          = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
        check({tag, ".pc"}, pc, exp_pc);
        check({tag, ".instr"}, instr, exp_word(exp_pc, r | rv));
    endtask

    initial begin
        n_pass         = 0;
        n_total        = 0;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            dut.u_imem.mem[i] = 32'hC0DE_0000 | 32'(i);
        end

        cyc(1'b1, 1'b0, 32'h0, 32'h0000_0000, "rst0");
        cyc(1'b1, 1'b0, 32'h0, 32'h0000_0000, "rst1");
        cyc(1'b1, 1'b0, 32'h0, 32'h0000_0000, "rst2");
        cyc(1'b1, 1'b1, 32'h100, 32'h0000_0000, "rst_over_redir");

        cyc(1'b0, 1'b0, 32'h0, 32'h0000_0004, "seq1");
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_0008, "seq2");

        cyc(1'b0, 1'b1, 32'h100, 32'h0000_0100, "redir");
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_0104, "redir_next");

        cyc(1'b0, 1'b1, 32'h107, 32'h0000_0104, "align");
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_0108, "align_next");

        cyc(1'b0, 1'b1, 32'h200, 32'h0000_0200, "hold0");
        cyc(1'b0, 1'b1, 32'h302, 32'h0000_0300, "hold1");
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_0304, "hold_rel");

        cyc(1'b0, 1'b1, 32'hFFC, 32'h0000_0FFC, "last_word");
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_1000, "past_end");
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_1004, "no_alias");
        cyc(1'b0, 1'b1, 32'h1000, 32'h0000_1000, "redir_oob");
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_1004, "redir_oob_next");

        cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, "top");
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_0000, "wrap");
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_0004, "wrap_next");

        cyc(1'b0, 1'b1, 32'h40, 32'h0000_0040, "mid_redir");
        cyc(1'b1, 1'b1, 32'h80, 32'h0000_0000, "mid_reset");
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_0004, "after_reset");
        cyc(1'b0, 1'b0, 32'h0, 32'h0000_0008, "after_reset2");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
